// File: rtl/lap_timer.sv
// rtl/lap_timer.sv - BCD stopwatch / countdown timer with a lap-capture FIFO.
// Optional feature macro: STOPWATCH_FLASH_BLINK_EN (blinking expiry flash).
module lap_timer #(
    parameter int TICK_DIV   = 10000000,
    parameter int MIN_DIGITS = 2,
    parameter int LAP_DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       clear,
    input  logic                       countdown,
    input  logic                       timeset,
    input  logic [4*MIN_DIGITS+11:0]   preset_bcd,
    input  logic                       lap,
    input  logic                       lap_rd,
    output logic [4*MIN_DIGITS+11:0]   time_bcd,
    output logic [4*MIN_DIGITS+11:0]   lap_bcd,
    output logic [$clog2(LAP_DEPTH):0] lap_count,
    output logic                       running,
    output logic                       flash
);
    localparam int TW = 4*MIN_DIGITS+12;
    localparam int ND = MIN_DIGITS+3;
    localparam int AW = $clog2(LAP_DEPTH);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV-1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(LAP_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXPIRED} state_t;

    // Digit 0 = tenths, 1 = seconds ones, 2 = seconds tens, 3.. = minutes.
    function automatic logic [3:0] digit_max(input int idx);
        return (idx == 2) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [TW-1:0] bcd_clamp(input logic [TW-1:0] t);
        logic [TW-1:0] r;
        r = t;
        for (int i = 0; i < ND; i++)
            if (t[4*i +: 4] > digit_max(i)) r[4*i +: 4] = digit_max(i);
        return r;
    endfunction

    function automatic logic [TW-1:0] bcd_step(input logic [TW-1:0] t, input logic down);
        logic [TW-1:0] r;
        logic [3:0]    d;
        logic          carry;
        r     = t;
        carry = 1'b1;
        for (int i = 0; i < ND; i++) begin
            d = t[4*i +: 4];
            if (carry) begin
                if (down) begin
                    carry = (d == 4'd0);
                    d     = carry ? digit_max(i) : d - 4'd1;
                end else begin
                    carry = (d >= digit_max(i));
                    d     = carry ? 4'd0 : d + 4'd1;
                end
            end
            r[4*i +: 4] = d;
        end
        return r;
    endfunction

    logic [1:0]    sync_q;
    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] time_q, time_d;
    logic          flash_q, flash_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [TW-1:0] lap_mem [LAP_DEPTH];
    logic          tick, push, pop, push_ok, flush;
`ifdef STOPWATCH_FLASH_BLINK_EN
    logic [2:0]    blink_q, blink_d;
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        presc_d = presc_q;
        time_d  = time_q;
        tick    = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        // Nothing moves until the released reset has crossed the synchroniser.
        if (sync_q[1]) begin
            tick = (presc_q == PRESC_MAX);
            pop  = lap_rd && (count_q != '0);
            if (clear) begin
                state_d = S_IDLE;
                time_d  = '0;
                presc_d = '0;
                flush   = 1'b1;
            end else begin
                case (state_q)
                    S_IDLE, S_PAUSE: begin
                        if (timeset) begin
                            time_d = bcd_clamp(preset_bcd);
                        end else if (start) begin
                            if (state_q == S_IDLE) begin
                                mode_d  = countdown;
                                presc_d = '0;
                            end
                            state_d = (mode_d && time_q == '0) ? S_EXPIRED : S_RUN;
                        end else begin
                            push = lap && (state_q == S_PAUSE);
                        end
                    end
                    S_RUN: begin
                        if (stop) begin
                            state_d = S_PAUSE;
                        end else begin
                            push    = lap;
                            presc_d = tick ? '0 : presc_q + PRESC_ONE;
                            if (tick) time_d = bcd_step(time_q, mode_q);
                            if (mode_q && time_d == '0) state_d = S_EXPIRED;
                        end
                    end
                    default: begin
`ifdef STOPWATCH_FLASH_BLINK_EN
                        presc_d = tick ? '0 : presc_q + PRESC_ONE;
`endif
                    end
                endcase
            end
        end

        // A pop frees a slot on the same edge, so a full FIFO still accepts.
        push_ok  = push && ((count_q != CNT_FULL) || pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push_ok && !pop)      count_d = count_q + CNT_ONE;
            else if (pop && !push_ok) count_d = count_q - CNT_ONE;
        end

`ifdef STOPWATCH_FLASH_BLINK_EN
        blink_d = blink_q;
        flash_d = 1'b0;
        if (state_d == S_EXPIRED) begin
            if (state_q != S_EXPIRED) begin
                flash_d = 1'b1;
                blink_d = '0;
            end else begin
                flash_d = flash_q;
                if (tick) begin
                    if (blink_q == 3'd4) begin
                        blink_d = '0;
                        flash_d = ~flash_q;
                    end else begin
                        blink_d = blink_q + 3'd1;
                    end
                end
            end
        end
`else
        flash_d = (state_d == S_EXPIRED);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q   <= '0;
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            presc_q  <= '0;
            time_q   <= '0;
            flash_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            sync_q   <= {sync_q[0], 1'b1};
            state_q  <= state_d;
            mode_q   <= mode_d;
            presc_q  <= presc_d;
            time_q   <= time_d;
            flash_q  <= flash_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef STOPWATCH_FLASH_BLINK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) blink_q <= '0;
        else        blink_q <= blink_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (push_ok) lap_mem[wr_ptr_q] <= time_q;
    end

    assign time_bcd  = time_q;
    assign lap_bcd   = (count_q == '0) ? '0 : lap_mem[rd_ptr_q];
    assign lap_count = count_q;
    assign running   = (state_q == S_RUN);
    assign flash     = flash_q;
endmodule

// File: tb/tb_lap_timer.sv
// tb/tb_lap_timer.sv - directed and randomised bench for lap_timer with an integer-time model.
module tb_lap_timer;
    localparam int TD   = 2;
    localparam int MD   = 2;
    localparam int LD   = 4;
    localparam int TW   = 4*MD+12;
    localparam int CW   = $clog2(LD)+1;
    localparam int MAXT = (10**MD)*600 - 1;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

    logic clk = 1'b0, reset = 1'b1;
    logic start = 1'b0, stop = 1'b0, clear = 1'b0, countdown = 1'b0;
    logic timeset = 1'b0, lap = 1'b0, lap_rd = 1'b0;
    logic [TW-1:0] preset_bcd = '0;
    logic [TW-1:0] time_bcd, lap_bcd;
    logic [CW-1:0] lap_count;
    logic          running, flash;

    lap_timer #(.TICK_DIV(TD), .MIN_DIGITS(MD), .LAP_DEPTH(LD)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .countdown(countdown), .timeset(timeset), .preset_bcd(preset_bcd),
        .lap(lap), .lap_rd(lap_rd), .time_bcd(time_bcd), .lap_bcd(lap_bcd),
        .lap_count(lap_count), .running(running), .flash(flash)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;
    // Model: time as integer tenths of a second, laps as a queue.
    int  m_st, m_t, m_pc, m_hold;
    bit  m_down;
    int  m_q[$];

    function automatic logic [TW-1:0] to_bcd(input int v);
        logic [TW-1:0] r;
        int m;
        r = '0;
        r[3:0]  = 4'(v % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[11:8] = 4'((v / 100) % 6);
        m = v / 600;
        for (int i = 0; i < MD; i++) begin
            r[12+4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic int clamp_val(input logic [TW-1:0] p);
        int d, v, mult;
        d = int'(p[3:0]);  v = (d > 9) ? 9 : d;
        d = int'(p[7:4]);  v += 10 * ((d > 9) ? 9 : d);
        d = int'(p[11:8]); v += 100 * ((d > 5) ? 5 : d);
        mult = 600;
        for (int i = 0; i < MD; i++) begin
            d = int'(p[12+4*i +: 4]);
            v += mult * ((d > 9) ? 9 : d);
            mult = mult * 10;
        end
        return v;
    endfunction

    task automatic m_reset();
        m_st = M_IDLE; m_t = 0; m_pc = 0; m_hold = 2; m_down = 0;
        m_q.delete();
    endtask

    task automatic set_reset(input logic v);
        reset = v;
        if (!v) m_reset();
    endtask

    task automatic model_edge();
        bit do_push, do_pop;
        int old_t;
        if (!reset) return;
        if (m_hold > 0) begin m_hold--; return; end
        old_t   = m_t;
        do_push = 0;
        do_pop  = lap_rd && (m_q.size() > 0);
        if (clear) begin
            m_st = M_IDLE; m_t = 0; m_pc = 0; m_q.delete();
            return;
        end
        case (m_st)
            M_IDLE, M_PAUSE: begin
                if (timeset) m_t = clamp_val(preset_bcd);
                else if (start) begin
                    if (m_st == M_IDLE) begin m_down = countdown; m_pc = 0; end
                    m_st = (m_down && m_t == 0) ? M_EXP : M_RUN;
                end else do_push = lap && (m_st == M_PAUSE);
            end
            M_RUN: begin
                if (stop) m_st = M_PAUSE;
                else begin
                    do_push = lap;
                    if (m_pc == TD-1) begin
                        m_pc = 0;
                        if (m_down) begin
                            m_t = m_t - 1;
                            if (m_t == 0) m_st = M_EXP;
                        end else m_t = (m_t == MAXT) ? 0 : m_t + 1;
                    end else m_pc++;
                end
            end
            default: ;
        endcase
        if (do_pop) void'(m_q.pop_front());
        if (do_push && m_q.size() < LD) m_q.push_back(old_t);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    task automatic test_reset();
        m_reset();
        #2 set_reset(1'b0);
        #1;
        n_cmp++;
        if (time_bcd !== '0 || lap_bcd !== '0 || lap_count !== '0 || running !== 1'b0 || flash !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs time=%h lap=%h cnt=%0d run=%b flash=%b required all zero",
                     time_bcd, lap_bcd, lap_count, running, flash);
        end
        step(); step();
        set_reset(1'b1);
        countdown = 1'b0; start = 1'b1;
        step();
        n_cmp++;
        if (running !== 1'b0) begin
            n_fail++; $display("FAIL reset_sync_edge1 running=%b required 0", running);
        end
        step(); step();
        n_cmp++;
        if (running !== (m_st == M_RUN)) begin
            n_fail++; $display("FAIL reset_sync_run running=%b required %b", running, m_st == M_RUN);
        end
        start = 1'b0;
        do_clear();
    endtask

    task automatic test_count_up();
        do_clear();
        countdown = 1'b0; start = 1'b1;
        repeat (25) step();
        start = 1'b0;
        n_cmp++;
        if (time_bcd !== 20'h00012 || running !== 1'b1) begin
            n_fail++; $display("FAIL count_up_25 time=%h run=%b required 00012 1", time_bcd, running);
        end
    endtask

    task automatic test_countdown_expire();
        do_clear();
        preset_bcd = 20'h00003; timeset = 1'b1; step(); timeset = 1'b0;
        countdown = 1'b1; start = 1'b1; step(); start = 1'b0;
        repeat (5) step();
        n_cmp++;
        if (time_bcd !== 20'h00001 || running !== 1'b1 || flash !== 1'b0) begin
            n_fail++; $display("FAIL cd_before time=%h run=%b flash=%b required 00001 1 0", time_bcd, running, flash);
        end
        step();
        n_cmp++;
        if (time_bcd !== '0 || running !== 1'b0 || flash !== 1'b1) begin
            n_fail++; $display("FAIL cd_expire time=%h run=%b flash=%b required 00000 0 1", time_bcd, running, flash);
        end
        start = 1'b1; repeat (4) step(); start = 1'b0;
        n_cmp++;
        if (time_bcd !== '0 || running !== 1'b0 || flash !== 1'b1) begin
            n_fail++; $display("FAIL cd_hold time=%h run=%b flash=%b required 00000 0 1", time_bcd, running, flash);
        end
        do_clear();
        n_cmp++;
        if (flash !== 1'b0) begin
            n_fail++; $display("FAIL cd_clear flash=%b required 0", flash);
        end
        // Start at zero in countdown mode expires immediately.
        countdown = 1'b1; start = 1'b1; step(); start = 1'b0;
        n_cmp++;
        if (flash !== 1'b1 || running !== 1'b0) begin
            n_fail++; $display("FAIL cd_zero_start flash=%b run=%b required 1 0", flash, running);
        end
        countdown = 1'b0;
        do_clear();
    endtask

    task automatic test_wrap_and_clamp();
        do_clear();
        preset_bcd = 20'hAB6CF; timeset = 1'b1; step(); timeset = 1'b0;
        n_cmp++;
        if (time_bcd !== 20'h99599) begin
            n_fail++; $display("FAIL clamp time=%h required 99599", time_bcd);
        end
        countdown = 1'b0; start = 1'b1; step(); start = 1'b0;
        preset_bcd = 20'h00005; timeset = 1'b1; step(); timeset = 1'b0;
        n_cmp++;
        if (time_bcd !== 20'h99599) begin
            n_fail++; $display("FAIL timeset_in_run time=%h required 99599", time_bcd);
        end
        step();
        n_cmp++;
        if (time_bcd !== '0 || running !== 1'b1) begin
            n_fail++; $display("FAIL wrap time=%h run=%b required 00000 1", time_bcd, running);
        end
        do_clear();
    endtask

    task automatic test_laps();
        do_clear();
        countdown = 1'b0; start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            repeat (3) step();
            lap = 1'b1; step(); lap = 1'b0;
        end
        n_cmp++;
        if (lap_count !== CW'(4)) begin
            n_fail++; $display("FAIL lap_full count=%0d required 4", lap_count);
        end
        stop = 1'b1; step(); stop = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (lap_bcd !== to_bcd(m_q[0])) begin
                n_fail++; $display("FAIL lap_read%0d lap=%h required %h", k, lap_bcd, to_bcd(m_q[0]));
            end
            lap_rd = 1'b1; step(); lap_rd = 1'b0;
        end
        n_cmp++;
        if (lap_bcd !== '0 || lap_count !== '0) begin
            n_fail++; $display("FAIL lap_empty lap=%h count=%0d required 0 0", lap_bcd, lap_count);
        end
        lap = 1'b1; repeat (4) step();
        lap_rd = 1'b1; step(); lap = 1'b0; lap_rd = 1'b0;
        n_cmp++;
        if (lap_count !== CW'(4) || lap_bcd !== to_bcd(m_q[0])) begin
            n_fail++; $display("FAIL lap_push_pop_full count=%0d lap=%h required 4 %h", lap_count, lap_bcd, to_bcd(m_q[0]));
        end
        do_clear();
        n_cmp++;
        if (lap_count !== '0 || time_bcd !== '0) begin
            n_fail++; $display("FAIL lap_clear count=%0d time=%h required 0 0", lap_count, time_bcd);
        end
    endtask

    task automatic test_reset_midrun();
        do_clear();
        countdown = 1'b0; start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 400 && m_t != 74; i++) step();
        n_cmp++;
        if (time_bcd !== 20'h00074) begin
            n_fail++; $display("FAIL midrun_reach time=%h required 00074", time_bcd);
        end
        step();
        set_reset(1'b0);
        #1;
        n_cmp++;
        if (time_bcd !== '0 || lap_bcd !== '0 || lap_count !== '0 || running !== 1'b0 || flash !== 1'b0) begin
            n_fail++; $display("FAIL midrun_reset time=%h lap=%h cnt=%0d run=%b flash=%b required all zero",
                               time_bcd, lap_bcd, lap_count, running, flash);
        end
        step();
        set_reset(1'b1);
        start = 1'b1;
        repeat (4) step();
        n_cmp++;
        if (time_bcd !== '0 || running !== 1'b1) begin
            n_fail++; $display("FAIL midrun_resume0 time=%h run=%b required 00000 1", time_bcd, running);
        end
        step();
        start = 1'b0;
        n_cmp++;
        if (time_bcd !== 20'h00001) begin
            n_fail++; $display("FAIL midrun_resume1 time=%h required 00001", time_bcd);
        end
    endtask

    task automatic test_random();
        logic [TW-1:0] exp_lap;
        do_clear();
        for (int c = 0; c < 3000; c++) begin
            clear      = ($urandom_range(0, 99) < 2);
            timeset    = ($urandom_range(0, 19) == 0);
            stop       = ($urandom_range(0, 24) == 0);
            start      = ($urandom_range(0, 3) == 0);
            lap        = ($urandom_range(0, 4) == 0);
            lap_rd     = ($urandom_range(0, 5) == 0);
            countdown  = ($urandom_range(0, 1) == 1);
            preset_bcd = ($urandom_range(0, 2) == 0) ? to_bcd(int'($urandom_range(0, 30))) : TW'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                set_reset(1'b0);
                #1;
                n_cmp++;
                if (time_bcd !== '0 || lap_count !== '0 || running !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_reset cyc=%0d time=%h cnt=%0d run=%b", c, time_bcd, lap_count, running);
                end
                step();
                set_reset(1'b1);
            end
            step();
            exp_lap = (m_q.size() > 0) ? to_bcd(m_q[0]) : '0;
            n_cmp++;
            if (time_bcd !== to_bcd(m_t)) begin
                n_fail++; $display("FAIL rnd_time cyc=%0d got=%h required %h", c, time_bcd, to_bcd(m_t));
            end
            n_cmp++;
            if (lap_bcd !== exp_lap) begin
                n_fail++; $display("FAIL rnd_lap cyc=%0d got=%h required %h", c, lap_bcd, exp_lap);
            end
            n_cmp++;
            if (lap_count !== CW'(m_q.size())) begin
                n_fail++; $display("FAIL rnd_count cyc=%0d got=%0d required %0d", c, lap_count, m_q.size());
            end
            n_cmp++;
            if (running !== (m_st == M_RUN)) begin
                n_fail++; $display("FAIL rnd_running cyc=%0d got=%b required %b", c, running, m_st == M_RUN);
            end
            n_cmp++;
            if (flash !== (m_st == M_EXP)) begin
                n_fail++; $display("FAIL rnd_flash cyc=%0d got=%b required %b", c, flash, m_st == M_EXP);
            end
        end
        clear = 1'b0; timeset = 1'b0; stop = 1'b0; start = 1'b0; lap = 1'b0; lap_rd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_countdown_expire();
        test_wrap_and_clamp();
        test_laps();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
